// File: rtl/sram_host_ctrl_pkg.sv
// Shared types for the SRAM host controller: FSM state encoding and its width.
package sram_host_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_host_ctrl_if.sv
// Request/response handshake plus SRAM control pins between a requester and the SRAM host controller.
// The bidirectional SRAM data bus is kept as a plain inout port on the controller.
interface sram_host_ctrl_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_is_wr;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_csb;
  logic                  sram_web;
  logic                  sram_oeb;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr,
    input  sram_addr, sram_csb, sram_web, sram_oeb
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_wr,
    output sram_addr, sram_csb, sram_web, sram_oeb
  );

endinterface

// File: rtl/sram_host_ctrl.sv
// Host-side single-port SRAM driver: sequences CSb/WEb/OEb from flops, owns the data tristate, returns read data.
// Optional write acknowledge response is enabled by defining SRAM_HOST_CTRL_WR_ACK_EN.
module sram_host_ctrl
  import sram_host_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  resetb,
  sram_host_ctrl_if.slave       bus,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  localparam int               CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);

  state_t                  r_state;
  logic                    r_reqReady;
  logic                    r_rspValid;
  logic [DATA_WIDTH-1:0]   r_rspRdata;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_csb;
  logic                    r_web;
  logic                    r_oeb;
  logic                    r_drive;
  logic [CNT_W-1:0]        r_cnt;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
  logic                    r_rspIsWr;
`endif

  // Pin values are loaded one edge ahead so every SRAM pin is a flop output for the whole access cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state    <= IDLE;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_oeb      <= 1'b1;
      r_drive    <= 1'b0;
      r_cnt      <= '0;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
      r_rspIsWr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (r_reqReady && bus.req_valid) begin
            r_reqReady <= 1'b0;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_csb      <= 1'b0;
            r_web      <= !bus.req_we;
            r_oeb      <= bus.req_we;
            r_drive    <= bus.req_we;
            r_cnt      <= CNT_LOAD;
            r_state    <= bus.req_we ? WR : RD;
          end else begin
            r_reqReady <= 1'b1;
          end
        end
        WR: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_drive <= 1'b0;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
          r_rspValid <= 1'b1;
          r_rspIsWr  <= 1'b1;
          r_rspRdata <= '0;
          r_state    <= RSP;
`else
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
`endif
        end
        RD: begin
          // The counter reaching zero marks the sample edge RD_LAT edges after the SRAM launch edge.
          if (r_cnt == '0) begin
            r_rspRdata <= sram_data;
            r_rspValid <= 1'b1;
            r_csb      <= 1'b1;
            r_oeb      <= 1'b1;
            r_state    <= RSP;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
            r_rspIsWr  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_reqReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.sram_addr = r_addr;
  assign bus.sram_csb  = r_csb;
  assign bus.sram_web  = r_web;
  assign bus.sram_oeb  = r_oeb;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
  assign bus.rsp_is_wr = r_rspIsWr;
`else
  assign bus.rsp_is_wr = 1'b0;
`endif

  assign sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl paired with a 16x2 behavioural SRAM; expected read data comes from a reference memory array.
// Write-ack expectations follow SRAM_HOST_CTRL_WR_ACK_EN.
module tb_sram_host_ctrl;

  localparam int DW     = 2;
  localparam int AW     = 4;
  localparam int RD_LAT = 1;
`ifdef SRAM_HOST_CTRL_WR_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb;
  wire  [DW-1:0] sram_data;

  sram_host_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_host_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .bus       (bus),
    .sram_data (sram_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: writes on the edge with CSb=WEb=0, launches read data on the edge with CSb=0/WEb=1.
  logic [DW-1:0] sramMem [16];
  logic [DW-1:0] sramDout;
  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) sramMem[bus.sram_addr] <= sram_data;
      else               sramDout <= sramMem[bus.sram_addr];
    end
  end
  assign sram_data = (!bus.sram_csb && !bus.sram_oeb) ? sramDout : 2'bzz;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t          vecs [32];
  logic [DW-1:0] refMem [16];
  int            testsRun    = 0;
  int            testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one request at a negedge and return at the negedge after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
  endtask

  task automatic runOp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int stall, input logic [DW-1:0] expRdata);
    int edges;
    logic [DW-1:0] heldData;
    applyStimulus(we, addr, wdata);
    checkOutput("csb_access", {31'b0, bus.sram_csb}, 32'd0);
    checkOutput("web_access", {31'b0, bus.sram_web}, {31'b0, !we});
    checkOutput("oeb_access", {31'b0, bus.sram_oeb}, {31'b0, we});
    checkOutput("addr_access", {28'b0, bus.sram_addr}, {28'b0, addr});
    checkOutput("ready_busy", {31'b0, bus.req_ready}, 32'd0);
    if (we) checkOutput("wdata_bus", {30'b0, sram_data}, {30'b0, wdata});
    if (!we || ACK) begin
      edges = 0;
      while (!bus.rsp_valid && edges < 20) begin
        @(negedge clk);
        edges++;
      end
      checkOutput("rsp_latency", edges, we ? 32'd1 : RD_LAT + 1);
      checkOutput("rsp_rdata", {30'b0, bus.rsp_rdata}, {30'b0, expRdata});
      checkOutput("rsp_is_wr", {31'b0, bus.rsp_is_wr}, {31'b0, we});
      heldData = bus.rsp_rdata;
      for (int s = 0; s < stall; s++) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        @(negedge clk);
        checkOutput("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
        checkOutput("stall_rdata", {30'b0, bus.rsp_rdata}, {30'b0, heldData});
        checkOutput("stall_ready", {31'b0, bus.req_ready}, 32'd0);
        checkOutput("stall_csb", {31'b0, bus.sram_csb}, 32'd1);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checkOutput("rsp_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("rsp_done_ready", {31'b0, bus.req_ready}, 32'd1);
    end else begin
      checkOutput("wr_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      checkOutput("wr_ready_back", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("wr_no_rsp2", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("wr_csb_idle", {31'b0, bus.sram_csb}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic          rwe;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    resetb        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 32; i++) begin
      vecs[i].we       = (i < 16);
      vecs[i].addr     = AW'(i % 16);
      vecs[i].wdata    = DW'(i % 4);
      vecs[i].expRdata = (i < 16) ? 2'b00 : DW'(i % 4);
    end

    // Reset held for three cycles, then released away from the clock edge.
    repeat (3) @(negedge clk);
    checkOutput("rst_csb", {31'b0, bus.sram_csb}, 32'd1);
    checkOutput("rst_web", {31'b0, bus.sram_web}, 32'd1);
    checkOutput("rst_oeb", {31'b0, bus.sram_oeb}, 32'd1);
    checkOutput("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_addr", {28'b0, bus.sram_addr}, 32'd0);
    resetb = 1'b1;
    #1;
    checkOutput("rel_ready_low", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("rel_ready_high", {31'b0, bus.req_ready}, 32'd1);

    // Single write then read of the same word.
    runOp(1'b1, 4'h5, 2'b10, 0, 2'b00);
    runOp(1'b0, 4'h5, 2'b00, 0, 2'b10);

    // Table: fill all 16 words with addr[1:0], then read them back in order.
    for (int i = 0; i < 32; i++) begin
      runOp(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, vecs[i].expRdata);
      if (vecs[i].we) refMem[vecs[i].addr] = vecs[i].wdata;
    end

    // Response held off for five cycles while a competing request is presented.
    runOp(1'b0, 4'h6, 2'b00, 5, refMem[6]);
    runOp(1'b0, 4'h0, 2'b00, 0, refMem[0]);

    // Reset asserted in the second read cycle.
    applyStimulus(1'b0, 4'h7, 2'b00);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    checkOutput("midrd_csb", {31'b0, bus.sram_csb}, 32'd1);
    checkOutput("midrd_oeb", {31'b0, bus.sram_oeb}, 32'd1);
    checkOutput("midrd_web", {31'b0, bus.sram_web}, 32'd1);
    checkOutput("midrd_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("midrd_rsp_valid2", {31'b0, bus.rsp_valid}, 32'd0);
    resetb = 1'b1;
    @(negedge clk);
    checkOutput("midrd_rsp_valid3", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("midrd_ready", {31'b0, bus.req_ready}, 32'd1);
    runOp(1'b0, 4'h7, 2'b00, 0, refMem[7]);

    // Write acknowledge behaviour depends on the build.
    runOp(1'b1, 4'hA, 2'b01, 0, 2'b00);
    refMem[4'hA] = 2'b01;
    runOp(1'b0, 4'hA, 2'b00, 0, refMem[4'hA]);

    // Random traffic against the reference memory.
    for (int k = 0; k < 120; k++) begin
      rwe   = 1'($urandom);
      raddr = AW'($urandom);
      rdata = DW'($urandom);
      if (rwe) begin
        runOp(1'b1, raddr, rdata, int'($urandom_range(0, 3)), 2'b00);
        refMem[raddr] = rdata;
      end else begin
        runOp(1'b0, raddr, 2'b00, int'($urandom_range(0, 3)), refMem[raddr]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
